// File: rtl/fxp_alu_pkg.sv
// fxp_alu_pkg: shared fixed-point ALU types, arbiter states and format constants
package fxp_alu_pkg;
    localparam int FXP_FRAC_BITS = 8;
    localparam int FXP_SIGN_BIT  = 23;
    typedef logic [23:0] fxp_t;
    typedef logic [3:0]  flags_t;
    typedef enum logic [2:0] {ADD = 3'b000, MUL = 3'b010} alu_op_t;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;
endpackage

// File: rtl/fxp_alu_arbiter_if.sv
// fxp_alu_arbiter_if: request/response channels plus shared-ALU link
//   master: requester + ALU side (drives requests, resp_ready, alu_res/flags)
//   slave : arbiter side (drives req_ready, responses, alu_a/b/ctrl, busy)
interface fxp_alu_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 24,
    parameter int CTRL_W  = 3,
    parameter int FLAGS_W = 4
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*CTRL_W-1:0] req_ctrl;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [NUM_REQ-1:0]        resp_ready;
    logic [DATA_W-1:0]         resp_result;
    logic [FLAGS_W-1:0]        resp_flags;
    logic [DATA_W-1:0]         alu_a;
    logic [DATA_W-1:0]         alu_b;
    logic [CTRL_W-1:0]         alu_ctrl;
    logic [DATA_W-1:0]         alu_res;
    logic [FLAGS_W-1:0]        alu_flags;
    logic                      busy;
    modport master (
        output req_valid, req_a, req_b, req_ctrl, resp_ready, alu_res, alu_flags,
        input  req_ready, resp_valid, resp_result, resp_flags, alu_a, alu_b, alu_ctrl, busy
    );
    modport slave (
        input  req_valid, req_a, req_b, req_ctrl, resp_ready, alu_res, alu_flags,
        output req_ready, resp_valid, resp_result, resp_flags, alu_a, alu_b, alu_ctrl, busy
    );
endinterface

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: first set request at or after ptr, wrapping modulo N
//   req: request vector, ptr: search start, grant: chosen index, any: some request set
module rr_priority_picker #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant,
    output logic             any
);
    logic [IDX_W-1:0] idx;
    // Walk offsets from farthest to nearest so the nearest hit overwrites last.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = |req;
        for (int k = N - 1; k >= 0; k--) begin
            idx = IDX_W'((int'(ptr) + k) % N);
            if (req[idx]) grant = idx;
        end
    end
endmodule

// File: rtl/fxp_alu_arbiter.sv
// fxp_alu_arbiter: round-robin sharing of one combinational fixed-point ALU
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave modport - requests in, one-hot responses out, alu_* to the ALU, busy
module fxp_alu_arbiter
    import fxp_alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 24,
    parameter int CTRL_W  = 3,
    parameter int FLAGS_W = 4
) (
    input logic clk,
    input logic rst,
    fxp_alu_arbiter_if.slave bus
);
    localparam int IDX_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    arb_state_t state, state_n;
    logic [IDX_W-1:0] rr_ptr, grant, pick;
    logic any;
    logic [DATA_W-1:0] op_a, op_b, res;
    logic [CTRL_W-1:0] op_ctrl;
    logic [FLAGS_W-1:0] flags;
    rr_priority_picker #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req  (bus.req_valid),
        .ptr  (rr_ptr),
        .grant(pick),
        .any  (any)
    );
    always_ff @(posedge clk) state <= rst ? IDLE : state_n;
    // Acceptance is masked by rst so a reset cycle never hands out a grant.
    always_comb begin
        state_n        = state;
        bus.req_ready  = '0;
        bus.resp_valid = '0;
        case (state)
            IDLE: if (any && !rst) begin
                state_n = EXEC;
                bus.req_ready[pick] = 1'b1;
            end
            EXEC: state_n = RESP;
            RESP: begin
                bus.resp_valid[grant] = 1'b1;
                if (bus.resp_ready[grant]) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= '0;
            grant   <= '0;
            op_a    <= '0;
            op_b    <= '0;
            op_ctrl <= '0;
            res     <= '0;
            flags   <= '0;
        end else begin
            if (state == IDLE && any) begin
                grant   <= pick;
                op_a    <= bus.req_a[pick*DATA_W +: DATA_W];
                op_b    <= bus.req_b[pick*DATA_W +: DATA_W];
                op_ctrl <= bus.req_ctrl[pick*CTRL_W +: CTRL_W];
            end
            if (state == EXEC) begin
                res   <= bus.alu_res;
                flags <= bus.alu_flags;
            end
            if (state == RESP && bus.resp_ready[grant])
                rr_ptr <= grant == IDX_W'(NUM_REQ - 1) ? '0 : grant + 1'b1;
        end
    end
    assign bus.alu_a       = op_a;
    assign bus.alu_b       = op_b;
    assign bus.alu_ctrl    = op_ctrl;
    assign bus.resp_result = res;
    assign bus.resp_flags  = flags;
    assign bus.busy        = state != IDLE;
endmodule

// File: tb/tb_fxp_alu_arbiter.sv
// tb_fxp_alu_arbiter: directed bench with a stand-in sign-magnitude ALU and result scoreboard
module tb_fxp_alu_arbiter;
    import fxp_alu_pkg::*;
    typedef struct {
        int         idx;
        logic [23:0] res;
        logic [3:0]  fl;
    } exp_t;
    logic clk = 1'b0;
    logic rst;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [3:0] seq6 [3];
    fxp_alu_arbiter_if #(.NUM_REQ(4), .DATA_W(24), .CTRL_W(3), .FLAGS_W(4)) bus ();
    fxp_alu_arbiter #(.NUM_REQ(4), .DATA_W(24), .CTRL_W(3), .FLAGS_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    // Stand-in ALU: flags = {mul, overflow, sign, zero}.
    function automatic logic [27:0] alu_model(logic [23:0] a, logic [23:0] b, logic [2:0] c);
        logic [22:0] ma, mb, m;
        logic [45:0] p;
        logic [23:0] s;
        logic sg, ov;
        ma = a[22:0];
        mb = b[22:0];
        ov = 1'b0;
        if (c == MUL) begin
            p  = 46'(ma) * 46'(mb);
            m  = p[FXP_FRAC_BITS +: 23];
            ov = |p[45:31];
            sg = a[FXP_SIGN_BIT] ^ b[FXP_SIGN_BIT];
        end else if (a[23] == b[23]) begin
            s  = {1'b0, ma} + {1'b0, mb};
            m  = s[22:0];
            ov = s[23];
            sg = a[23];
        end else if (ma >= mb) begin
            m  = ma - mb;
            sg = a[23];
        end else begin
            m  = mb - ma;
            sg = b[23];
        end
        if (m == '0) sg = 1'b0;
        return {sg, m, c == MUL, ov, sg, m == '0};
    endfunction
    always_comb {bus.alu_res, bus.alu_flags} = alu_model(bus.alu_a, bus.alu_b, bus.alu_ctrl);
    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask
    task automatic drv;
        @(posedge clk);
        #1;
    endtask
    task automatic neg;
        @(negedge clk);
    endtask
    task automatic set_req(int i, logic [23:0] a, logic [23:0] b, logic [2:0] c);
        bus.req_a[i*24 +: 24]  = a;
        bus.req_b[i*24 +: 24]  = b;
        bus.req_ctrl[i*3 +: 3] = c;
    endtask
    task automatic do_reset;
        drv();
        rst = 1'b1;
        bus.req_valid  = '0;
        bus.resp_ready = '1;
        drv();
        rst = 1'b0;
        sb.delete();
    endtask
    // Scoreboard: push at acceptance, pop and compare at the response handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (|bus.req_ready) begin
                check("ready_onehot", 32'($onehot(bus.req_ready)), 1);
                for (int i = 0; i < 4; i++)
                    if (bus.req_ready[i]) begin
                        mon_e.idx = i;
                        {mon_e.res, mon_e.fl} = alu_model(bus.req_a[i*24 +: 24],
                            bus.req_b[i*24 +: 24], bus.req_ctrl[i*3 +: 3]);
                        sb.push_back(mon_e);
                    end
            end
            if (|(bus.resp_valid & bus.resp_ready)) begin
                if (sb.size() == 0) check("sb_unexpected", 32'(bus.resp_valid), 0);
                else begin
                    mon_e = sb.pop_front();
                    check("sb_idx", 32'(bus.resp_valid), 32'(1) << mon_e.idx);
                    check("sb_result", 32'(bus.resp_result), 32'(mon_e.res));
                    check("sb_flags", 32'(bus.resp_flags), 32'(mon_e.fl));
                end
            end
        end
    end
    initial begin
        rst = 1'b1;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_ctrl   = '0;
        bus.resp_ready = '1;
        seq6 = '{4'b0001, 4'b1000, 4'b0001};
        do_reset();
        neg();
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_req_ready", 32'(bus.req_ready), 0);
        check("rst_resp_valid", 32'(bus.resp_valid), 0);
        check("rst_alu_a", 32'(bus.alu_a), 0);
        check("rst_result", 32'(bus.resp_result), 0);
        check("rst_flags", 32'(bus.resp_flags), 0);
        // 3.125 + -0.75
        drv();
        set_req(1, 24'h000320, 24'h8000C0, ADD);
        bus.req_valid = 4'b0010;
        neg();
        check("t1_ready", 32'(bus.req_ready), 32'b0010);
        drv();
        bus.req_valid = '0;
        neg();
        check("t1_exec_ready", 32'(bus.req_ready), 0);
        check("t1_busy", 32'(bus.busy), 1);
        check("t1_alu_a", 32'(bus.alu_a), 32'h000320);
        check("t1_alu_b", 32'(bus.alu_b), 32'h8000C0);
        drv();
        neg();
        check("t1_resp_valid", 32'(bus.resp_valid), 32'b0010);
        check("t1_result", 32'(bus.resp_result), 32'h000260);
        check("t1_flags", 32'(bus.resp_flags), 0);
        drv();
        neg();
        check("t1_idle", 32'(bus.busy), 0);
        // -0.75 * 0.5625
        drv();
        set_req(1, 24'h8000C0, 24'h000090, MUL);
        bus.req_valid = 4'b0010;
        neg();
        check("t2_ready", 32'(bus.req_ready), 32'b0010);
        drv();
        bus.req_valid = '0;
        neg();
        drv();
        neg();
        check("t2_resp_valid", 32'(bus.resp_valid), 32'b0010);
        check("t2_result", 32'(bus.resp_result), 32'h80006C);
        check("t2_flags", 32'(bus.resp_flags), 32'b1010);
        drv();
        // All four requesters continuously valid: accepts 0,1,2,3,0
        do_reset();
        for (int i = 0; i < 4; i++)
            set_req(i, 24'(32'h000100 * (i + 1)), 24'h000180, i[0] ? MUL : ADD);
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            neg();
            check("t3_accept", 32'(bus.req_ready), 32'(1) << (k % 4));
            drv();
            neg();
            check("t3_gap", 32'(bus.req_ready), 0);
            drv();
            neg();
            check("t3_resp", 32'(bus.resp_valid), 32'(1) << (k % 4));
            drv();
            if (k == 4) bus.req_valid = '0;
        end
        // Response back-pressure on requester 2
        bus.resp_ready = 4'b1011;
        set_req(2, 24'h001000, 24'h000180, ADD);
        bus.req_valid = 4'b0100;
        neg();
        check("t4_ready", 32'(bus.req_ready), 32'b0100);
        drv();
        bus.req_valid = '0;
        neg();
        drv();
        set_req(0, 24'h000200, 24'h800100, ADD);
        bus.req_valid = 4'b0001;
        for (int h = 0; h < 5; h++) begin
            neg();
            check("t4_hold_valid", 32'(bus.resp_valid), 32'b0100);
            check("t4_hold_result", 32'(bus.resp_result), 32'h001180);
            check("t4_hold_busy", 32'(bus.busy), 1);
            check("t4_hold_ready", 32'(bus.req_ready), 0);
            drv();
        end
        bus.resp_ready = 4'b1111;
        neg();
        check("t4_still", 32'(bus.resp_valid), 32'b0100);
        drv();
        neg();
        check("t4_idle", 32'(bus.busy), 0);
        check("t4_next", 32'(bus.req_ready), 32'b0001);
        drv();
        bus.req_valid = '0;
        repeat (3) drv();
        // Reset during EXEC aborts the operation and clears rr_ptr
        set_req(3, 24'h000300, 24'h000100, ADD);
        bus.req_valid = 4'b1000;
        neg();
        check("t5_ready", 32'(bus.req_ready), 32'b1000);
        drv();
        bus.req_valid = '0;
        rst = 1'b1;
        neg();
        drv();
        rst = 1'b0;
        sb.delete();
        neg();
        check("t5_busy", 32'(bus.busy), 0);
        check("t5_resp_valid", 32'(bus.resp_valid), 0);
        check("t5_req_ready", 32'(bus.req_ready), 0);
        check("t5_alu_a", 32'(bus.alu_a), 0);
        check("t5_result", 32'(bus.resp_result), 0);
        drv();
        bus.req_valid = 4'b1111;
        neg();
        check("t5_ptr", 32'(bus.req_ready), 32'b0001);
        drv();
        bus.req_valid = '0;
        repeat (3) drv();
        // req0 always valid alongside req3: grants 0,3,0
        do_reset();
        bus.req_valid = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            neg();
            check("t6_grant", 32'(bus.req_ready), 32'(seq6[k]));
            drv();
            neg();
            drv();
            neg();
            check("t6_resp", 32'(bus.resp_valid), 32'(seq6[k]));
            drv();
            if (k == 2) bus.req_valid = '0;
        end
        repeat (3) drv();
        neg();
        check("sb_empty", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
